// File: rtl/cdc_mcp_tx_ctrl_if.sv
// Handshake and crossing bus between upstream logic, the MCP source controller and the destination.
// master: controller side; slave: upstream plus destination side.
interface cdc_mcp_tx_ctrl_if #(
    parameter int WIDTH     = 5,
    parameter int CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     DATA_I;
    logic                 VALID_I;
    logic                 READY_O;
    logic [WIDTH-1:0]     DATA_O;
    logic                 REQ_TOGGLE_O;
    logic                 ACK_TOGGLE_I;
    logic                 BUSY_O;
    logic                 DONE_O;
    logic [CNT_WIDTH-1:0] XFER_CNT_O;
    logic                 ERR_O;

    modport master (
        input  DATA_I, VALID_I, ACK_TOGGLE_I,
        output READY_O, DATA_O, REQ_TOGGLE_O, BUSY_O, DONE_O, XFER_CNT_O, ERR_O
    );

    modport slave (
        output DATA_I, VALID_I, ACK_TOGGLE_I,
        input  READY_O, DATA_O, REQ_TOGGLE_O, BUSY_O, DONE_O, XFER_CNT_O, ERR_O
    );
endinterface

// File: rtl/cdc_mcp_tx_ctrl.sv
// Toggle-based MCP source: launches a word on the accept edge, completes SYNC_STAGES edges after the ack toggle is first sampled.
// Backpressure: READY_O drops only while the one-entry pending buffer holds a word (and during reset).
module cdc_mcp_tx_ctrl #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    cdc_mcp_tx_ctrl_if.master     bus
);
    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [WIDTH-1:0]       pend_dat_q, pend_dat_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   req_q, req_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ready;
    logic                   accept;
    logic                   complete;

    assign ack_s    = sync_q[SYNC_STAGES-1];
    assign ready    = ~RST_I & ~pend_vld_q;
    assign accept   = bus.VALID_I & ready;
    assign complete = (state_q == WAIT_ACK) && (ack_s == req_q);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        req_d      = req_q;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                // An ack that moves while nothing is in flight means the two sides disagree.
                if (ack_s != req_q) err_d = 1'b1;
                if (accept) begin
                    data_d  = bus.DATA_I;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (complete) begin
                    done_d = 1'b1;
                    cnt_d  = cnt_q + CNT_WIDTH'(1);
                    if (pend_vld_q) begin
                        data_d     = pend_dat_q;
                        req_d      = ~req_q;
                        pend_vld_d = 1'b0;
                    end else if (accept) begin
                        data_d = bus.DATA_I;
                        req_d  = ~req_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    pend_vld_d = 1'b1;
                    pend_dat_d = bus.DATA_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            data_q     <= '0;
            req_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= '0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.ACK_TOGGLE_I};
            data_q     <= data_d;
            req_q      <= req_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.READY_O      = ready;
    assign bus.DATA_O       = data_q;
    assign bus.REQ_TOGGLE_O = req_q;
    assign bus.BUSY_O       = (state_q == WAIT_ACK);
    assign bus.DONE_O       = done_q;
    assign bus.XFER_CNT_O   = cnt_q;
    assign bus.ERR_O        = err_q;
endmodule

// File: tb/tb_cdc_mcp_tx_ctrl.sv
// Bench for cdc_mcp_tx_ctrl: directed protocol scenarios, then randomized traffic against a queue-based model.
module tb_cdc_mcp_tx_ctrl;
    localparam int W  = 5;
    localparam int SS = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdc_mcp_tx_ctrl_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    cdc_mcp_tx_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_WIDTH(CW)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic apply_reset();
        rst = 1'b1;
        bus.VALID_I = 1'b0;
        bus.DATA_I = '0;
        bus.ACK_TOGGLE_I = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.VALID_I = 1'b0;
        bus.DATA_I = '0;
        bus.ACK_TOGGLE_I = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (bus.READY_O !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", bus.READY_O); end
        @(negedge clk); @(negedge clk);
        n_vec++; if (bus.DATA_O !== 5'h00) begin n_err++; $display("FAIL rst_data got %h want 00", bus.DATA_O); end
        n_vec++; if (bus.REQ_TOGGLE_O !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", bus.REQ_TOGGLE_O); end
        n_vec++; if (bus.XFER_CNT_O !== 4'd0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", bus.XFER_CNT_O); end
        n_vec++; if ({bus.BUSY_O, bus.DONE_O, bus.ERR_O} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {bus.BUSY_O, bus.DONE_O, bus.ERR_O}); end
        rst = 1'b0;
        #1;
        n_vec++; if (bus.READY_O !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b want 1", bus.READY_O); end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.VALID_I = 1'b1; bus.DATA_I = 5'h15;
        @(negedge clk);
        bus.VALID_I = 1'b0;
        n_vec++; if (bus.DATA_O !== 5'h15) begin n_err++; $display("FAIL single_data got %h want 15", bus.DATA_O); end
        n_vec++; if (bus.REQ_TOGGLE_O !== 1'b1) begin n_err++; $display("FAIL single_req got %b want 1", bus.REQ_TOGGLE_O); end
        n_vec++; if (bus.BUSY_O !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", bus.BUSY_O); end
        repeat (8) @(negedge clk);
        n_vec++; if (bus.DONE_O !== 1'b0) begin n_err++; $display("FAIL single_early_done got %b want 0", bus.DONE_O); end
        bus.ACK_TOGGLE_I = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (bus.DONE_O !== (i == 2)) begin n_err++; $display("FAIL single_done[%0d] got %b want %b", i, bus.DONE_O, (i == 2)); end
        end
        n_vec++; if (bus.XFER_CNT_O !== 4'd1) begin n_err++; $display("FAIL single_cnt got %0d want 1", bus.XFER_CNT_O); end
        n_vec++; if (bus.BUSY_O !== 1'b0) begin n_err++; $display("FAIL single_idle got %b want 0", bus.BUSY_O); end
    endtask

    task automatic test_pending();
        bus.VALID_I = 1'b1; bus.DATA_I = 5'h01;
        @(negedge clk);
        n_vec++; if (bus.DATA_O !== 5'h01 || bus.REQ_TOGGLE_O !== 1'b0) begin n_err++; $display("FAIL pend_launch1 got %h/%b want 01/0", bus.DATA_O, bus.REQ_TOGGLE_O); end
        bus.DATA_I = 5'h02;
        @(negedge clk);
        bus.VALID_I = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++; if (bus.READY_O !== 1'b0) begin n_err++; $display("FAIL pend_ready_low[%0d] got %b want 0", i, bus.READY_O); end
        end
        bus.ACK_TOGGLE_I = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) begin
                n_vec++; if (bus.READY_O !== 1'b0 || bus.DATA_O !== 5'h01) begin n_err++; $display("FAIL pend_hold[%0d] got %b/%h want 0/01", i, bus.READY_O, bus.DATA_O); end
            end
        end
        n_vec++; if (bus.DATA_O !== 5'h02 || bus.REQ_TOGGLE_O !== 1'b1) begin n_err++; $display("FAIL pend_launch2 got %h/%b want 02/1", bus.DATA_O, bus.REQ_TOGGLE_O); end
        n_vec++; if (bus.DONE_O !== 1'b1 || bus.XFER_CNT_O !== 4'd2) begin n_err++; $display("FAIL pend_done got %b/%0d want 1/2", bus.DONE_O, bus.XFER_CNT_O); end
        n_vec++; if (bus.READY_O !== 1'b1 || bus.BUSY_O !== 1'b1) begin n_err++; $display("FAIL pend_ready_back got %b/%b want 1/1", bus.READY_O, bus.BUSY_O); end
        bus.ACK_TOGGLE_I = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.XFER_CNT_O !== 4'd3 || bus.BUSY_O !== 1'b0 || bus.DATA_O !== 5'h02) begin n_err++; $display("FAIL pend_end got %0d/%b/%h want 3/0/02", bus.XFER_CNT_O, bus.BUSY_O, bus.DATA_O); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        bus.VALID_I = 1'b1; bus.DATA_I = 5'h07;
        @(negedge clk);
        bus.VALID_I = 1'b0;
        n_vec++; if (bus.DATA_O !== 5'h07 || bus.REQ_TOGGLE_O !== 1'b0) begin n_err++; $display("FAIL byp_launch1 got %h/%b want 07/0", bus.DATA_O, bus.REQ_TOGGLE_O); end
        @(negedge clk);
        bus.ACK_TOGGLE_I = 1'b0;
        @(negedge clk); @(negedge clk);
        bus.VALID_I = 1'b1; bus.DATA_I = 5'h0A;
        @(negedge clk);
        bus.VALID_I = 1'b0;
        n_vec++; if (bus.DATA_O !== 5'h0A || bus.REQ_TOGGLE_O !== 1'b1) begin n_err++; $display("FAIL byp_launch2 got %h/%b want 0a/1", bus.DATA_O, bus.REQ_TOGGLE_O); end
        n_vec++; if (bus.BUSY_O !== 1'b1 || bus.DONE_O !== 1'b1 || bus.XFER_CNT_O !== 4'd4) begin n_err++; $display("FAIL byp_done got %b/%b/%0d want 1/1/4", bus.BUSY_O, bus.DONE_O, bus.XFER_CNT_O); end
        @(negedge clk);
        n_vec++; if (bus.BUSY_O !== 1'b1 || bus.DONE_O !== 1'b0) begin n_err++; $display("FAIL byp_no_idle got %b/%b want 1/0", bus.BUSY_O, bus.DONE_O); end
        bus.ACK_TOGGLE_I = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.XFER_CNT_O !== 4'd5 || bus.BUSY_O !== 1'b0 || bus.ERR_O !== 1'b0) begin n_err++; $display("FAIL byp_end got %0d/%b/%b want 5/0/0", bus.XFER_CNT_O, bus.BUSY_O, bus.ERR_O); end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        bus.ACK_TOGGLE_I = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (bus.ERR_O !== (i == 2)) begin n_err++; $display("FAIL spur_err[%0d] got %b want %b", i, bus.ERR_O, (i == 2)); end
            n_vec++; if (bus.DONE_O !== 1'b0 || bus.XFER_CNT_O !== 4'd5) begin n_err++; $display("FAIL spur_cnt[%0d] got %b/%0d want 0/5", i, bus.DONE_O, bus.XFER_CNT_O); end
        end
        bus.ACK_TOGGLE_I = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++; if (bus.ERR_O !== 1'b1 || bus.XFER_CNT_O !== 4'd5) begin n_err++; $display("FAIL spur_sticky got %b/%0d want 1/5", bus.ERR_O, bus.XFER_CNT_O); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.VALID_I = 1'b1; bus.DATA_I = 5'h11;
        @(negedge clk);
        bus.DATA_I = 5'h12;
        @(negedge clk);
        bus.VALID_I = 1'b0;
        n_vec++; if (bus.READY_O !== 1'b0 || bus.BUSY_O !== 1'b1) begin n_err++; $display("FAIL rmid_full got %b/%b want 0/1", bus.READY_O, bus.BUSY_O); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.DATA_O !== 5'h00 || bus.REQ_TOGGLE_O !== 1'b0) begin n_err++; $display("FAIL rmid_async got %h/%b want 00/0", bus.DATA_O, bus.REQ_TOGGLE_O); end
        n_vec++; if ({bus.BUSY_O, bus.DONE_O, bus.ERR_O, bus.READY_O} !== 4'b0000 || bus.XFER_CNT_O !== 4'd0) begin n_err++; $display("FAIL rmid_flags got %b/%0d want 0000/0", {bus.BUSY_O, bus.DONE_O, bus.ERR_O, bus.READY_O}, bus.XFER_CNT_O); end
        @(negedge clk);
        rst = 1'b0;
        bus.VALID_I = 1'b1; bus.DATA_I = 5'h13;
        @(negedge clk);
        bus.VALID_I = 1'b0;
        n_vec++; if (bus.DATA_O !== 5'h13 || bus.REQ_TOGGLE_O !== 1'b1) begin n_err++; $display("FAIL rmid_launch got %h/%b want 13/1", bus.DATA_O, bus.REQ_TOGGLE_O); end
        bus.ACK_TOGGLE_I = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.DONE_O !== 1'b1 || bus.XFER_CNT_O !== 4'd1 || bus.ERR_O !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b/%0d/%b want 1/1/0", bus.DONE_O, bus.XFER_CNT_O, bus.ERR_O); end
        @(negedge clk);
        n_vec++; if (bus.BUSY_O !== 1'b0 || bus.DATA_O !== 5'h13) begin n_err++; $display("FAIL rmid_drop_pend got %b/%h want 0/13", bus.BUSY_O, bus.DATA_O); end
    endtask

    // Model: words cross in accept order, one at a time; a word waits only while another is in flight.
    task automatic test_random_wrap();
        logic [W-1:0] q[$];
        logic [W-1:0] exp_data;
        logic         exp_req;
        logic         exp_done;
        int n_acc, n_done, launched, cyc, done_cyc, dly;
        apply_reset();
        exp_data = '0; exp_req = 1'b0;
        n_acc = 0; n_done = 0; launched = 0; cyc = 0; done_cyc = -1; dly = -1;
        while (n_done < 17 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            exp_done = (cyc == done_cyc);
            n_vec++; if (bus.DONE_O !== exp_done) begin n_err++; $display("FAIL rnd_done cyc %0d got %b want %b", cyc, bus.DONE_O, exp_done); end
            if (exp_done) n_done++;
            if (bus.REQ_TOGGLE_O !== exp_req) begin
                n_vec++; if (q.size() == 0 || launched != n_done) begin n_err++; $display("FAIL rnd_launch cyc %0d got launch want none (queued %0d, inflight %0d)", cyc, q.size(), launched - n_done); end
                if (q.size() != 0) exp_data = q.pop_front();
                exp_req = ~exp_req;
                launched++;
            end
            n_vec++; if (bus.DATA_O !== exp_data) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, bus.DATA_O, exp_data); end
            n_vec++; if (bus.READY_O !== (q.size() == 0)) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, bus.READY_O, (q.size() == 0)); end
            n_vec++; if (bus.BUSY_O !== (launched > n_done)) begin n_err++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, bus.BUSY_O, (launched > n_done)); end
            n_vec++; if ((q.size() != 0 && launched == n_done) || bus.ERR_O !== 1'b0) begin n_err++; $display("FAIL rnd_stall cyc %0d got queued %0d err %b want launch, err 0", cyc, q.size(), bus.ERR_O); end
            if (dly < 0 && bus.ACK_TOGGLE_I != exp_req) dly = $urandom_range(0, 3);
            if (dly == 0) begin
                bus.ACK_TOGGLE_I = exp_req;
                done_cyc = cyc + SS + 1;
                dly = -1;
            end else if (dly > 0) begin
                dly--;
            end
            if (n_acc < 17 && $urandom_range(0, 1) == 1) begin
                bus.VALID_I = 1'b1;
                bus.DATA_I = W'($urandom_range(0, 31));
                if (bus.READY_O) begin
                    q.push_back(bus.DATA_I);
                    n_acc++;
                end
            end else begin
                bus.VALID_I = 1'b0;
            end
        end
        bus.VALID_I = 1'b0;
        n_vec++; if (n_done != 17) begin n_err++; $display("FAIL rnd_timeout got %0d completions want 17", n_done); end
        n_vec++; if (bus.XFER_CNT_O !== 4'd1) begin n_err++; $display("FAIL rnd_wrap_cnt got %0d want 1", bus.XFER_CNT_O); end
        @(negedge clk);
        n_vec++; if (bus.BUSY_O !== 1'b0 || bus.DONE_O !== 1'b0) begin n_err++; $display("FAIL rnd_final got %b/%b want 0/0", bus.BUSY_O, bus.DONE_O); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pending();
        test_bypass();
        test_spurious();
        test_reset_mid();
        test_random_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end
endmodule

// File: doc/cdc_mcp_tx_ctrl.md
# cdc_mcp_tx_ctrl

Source-side controller for the toggle-based multi-cycle-path (MCP) clock domain crossing. It accepts words from local logic over a valid/ready handshake and holds each word stable on `DATA_O` for the whole crossing. It announces each word by inverting `REQ_TOGGLE_O` and waits until the destination returns an acknowledge toggle, which it synchronizes internally, before releasing the next word. A one-entry pending buffer lets upstream hand over the next word while a crossing is in flight.

## Interface
- `WIDTH`, 5: data width in bits.
- `SYNC_STAGES`, 2: flops in the `ACK_TOGGLE_I` synchronizer; legal values ≥ 2.
- `CNT_WIDTH`, 16: width of the completed-transfer counter.

- `CLK_I` in 1: single clock of the source domain.
- `RST_I` in 1: reset, asynchronous, active-high.
- `DATA_I` in WIDTH: word offered by upstream.
- `VALID_I` in 1: `DATA_I` is valid.
- `READY_O` out 1: a word is accepted on any edge where `VALID_I & READY_O`.
- `DATA_O` out WIDTH: word currently crossing; stable from launch until completion.
- `REQ_TOGGLE_O` out 1: request toggle to the destination; inverts once per launch.
- `ACK_TOGGLE_I` in 1: acknowledge toggle from the destination; asynchronous to `CLK_I`.
- `BUSY_O` out 1: high while in `WAIT_ACK`.
- `DONE_O` out 1: one-cycle pulse per completed crossing.
- `XFER_CNT_O` out CNT_WIDTH: count of completed crossings.
- `ERR_O` out 1: sticky protocol error flag.

## Operation
- Reset values, asynchronous: `DATA_O`=0, `REQ_TOGGLE_O`=0, synchronizer flops=0, pending buffer empty, state `IDLE`, `DONE_O`=0, `XFER_CNT_O`=0, `ERR_O`=0.
- `READY_O` = not `RST_I` and pending buffer empty. It is forced to 0 while `RST_I` is high.
- `ack_s` is the last stage of the `SYNC_STAGES` synchronizer sampling `ACK_TOGGLE_I`.
- Acknowledge convention: the destination drives `ACK_TOGGLE_I` to equal `REQ_TOGGLE_O` after it captures `DATA_O`. A crossing is complete when `ack_s == REQ_TOGGLE_O` in state `WAIT_ACK`.
- Launch sets `DATA_O` to the launched word, inverts `REQ_TOGGLE_O`, and moves the state to `WAIT_ACK`. All three updates happen on the same edge.
- State `IDLE`:
  - On accept, launch the accepted word on that edge. The pending buffer is not used.
  - If `ack_s != REQ_TOGGLE_O`, set `ERR_O` (spurious acknowledge).
- State `WAIT_ACK`, without completion:
  - On accept, store the word in the pending buffer.
  - `DATA_O` and `REQ_TOGGLE_O` hold.
- State `WAIT_ACK`, on the completion edge:
  - `DONE_O` is 1 for the following cycle.
  - `XFER_CNT_O` increments, wrapping modulo 2^CNT_WIDTH.
  - Then exactly one of the following applies, in priority order:
    - Pending buffer full: launch the pending word and empty the buffer. No accept occurs on this edge because `READY_O` is 0.
    - Pending buffer empty and accept on this edge: launch the accepted word directly (bypass).
    - Otherwise: go to `IDLE`.
- `DONE_O` and `XFER_CNT_O` are registered, so both update on the completion edge.
- Mid-operation reset: all in-flight and pending words are discarded and `REQ_TOGGLE_O` returns to 0. The destination must be reset in the same window so that its acknowledge also returns to 0; otherwise `ERR_O` sets after reset.

## Timing
- Accept at edge t in `IDLE`: `DATA_O` and `REQ_TOGGLE_O` are new after t, and `BUSY_O` is 1 after t.
- `ACK_TOGGLE_I` change first sampled at edge k: `ack_s` updates after edge k+SYNC_STAGES−1.
- Completion edge is k+SYNC_STAGES. After it, `DONE_O`=1 for one cycle and the count has incremented.
- Back-to-back launch from the pending buffer happens on the completion edge. `READY_O` returns to 1 on the cycle after that edge.
- Minimum spacing between launches is SYNC_STAGES+1 cycles after the acknowledge change, plus the destination's own round-trip.
- `DATA_O` never changes except on a launch edge.

## Test plan
- Single word: with WIDTH=5, accept 0x15 at edge 10; acknowledge toggles at edge 20.
  - Required: `DATA_O`=0x15 and `REQ_TOGGLE_O`=1 after edge 10.
  - Required: `DONE_O` high only in the cycle after edge 22, and `XFER_CNT_O`=1.
- Pending buffer: accept 0x01, then 0x02 while `BUSY_O`=1.
  - Required: `READY_O`=0 until the first completion.
  - Required: `DATA_O`=0x02 and `REQ_TOGGLE_O` inverted on that completion edge.
  - Required: `READY_O`=1 one cycle later.
- Bypass: with the pending buffer empty, assert `VALID_I` with 0x0A on the completion edge.
  - Required: launch of 0x0A on that edge, state stays `WAIT_ACK`, no `IDLE` cycle in between.
- Spurious acknowledge: in `IDLE`, toggle `ACK_TOGGLE_I`.
  - Required: `ERR_O`=1 after SYNC_STAGES+1 edges, held until reset.
  - Required: `DONE_O` and the count remain unchanged.
- Reset mid-crossing: assert `RST_I` with the pending buffer full.
  - Required: all outputs return to reset values immediately, without waiting for a clock edge.
  - Required: after release with the acknowledge at 0, a new transfer completes with count=1.
- Counter wrap: with CNT_WIDTH=4, run 17 transfers.
  - Required: `XFER_CNT_O`=1 at the end, and every `DATA_O` is held stable throughout its crossing.
